// File: rtl/custom_reg_ip_pkg.sv
// custom_reg_ip_pkg: shared types and the write-result helper for the register bridge
package custom_reg_ip_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {STORE = 2'd0, ACC_WRAP = 2'd1, ACC_SAT = 2'd2, RSVD = 2'd3} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, VALID = 2'd1, VALID_PEND = 2'd2} rd_state_e;
  // Returns {carry, next}; operands are zero-extended to MAX_W and w is the live width
  function automatic logic [MAX_W:0] calc_next(input mode_e mode, input logic [MAX_W-1:0] r,
                                              input logic [MAX_W-1:0] d, input int unsigned w);
    logic [MAX_W:0] sum, top, mask, nxt;
    logic acc, carry;
    sum = {1'b0, r} + {1'b0, d};
    top = (MAX_W + 1)'(1) << w;
    mask = top - (MAX_W + 1)'(1);
    carry = |(sum & top);
    acc = (mode == ACC_WRAP) || (mode == ACC_SAT);
    nxt = !acc ? {1'b0, d} : (mode == ACC_SAT && carry) ? mask : sum & mask;
    return {acc & carry, nxt[MAX_W-1:0]};
  endfunction
endpackage

// File: rtl/custom_reg_ip_array_ch.sv
// custom_reg_ip_array_ch: one channel -- register, write ack, sticky overflow and read-back FSM
module custom_reg_ip_ch
  import custom_reg_ip_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  input  logic [1:0]            mode,
  output logic                  ack,
  input  logic                  ovf_clr,
  output logic                  ovf,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  rready
);
  rd_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] reg_q, reg_d, nxt, snap_q;
  logic [MAX_W:0] res;
  logic res_unused, carry, hs, load, ack_q, ovf_q;
  assign res = calc_next(mode_e'(mode), MAX_W'(reg_q), MAX_W'(wdata), DATA_WIDTH);
  assign res_unused = ^res;
  assign nxt = res[DATA_WIDTH-1:0];
  assign carry = res[MAX_W];
  assign reg_d = we ? nxt : reg_q;
  assign rvalid = state_q != IDLE;
  assign hs = rvalid & rready;
  assign ack = ack_q;
  assign ovf = ovf_q;
  assign rdata = snap_q;
  // Every snapshot load takes the post-edge register value, same-cycle write included
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = we ? VALID : IDLE;
        load = we;
      end
      VALID: begin
        state_d = hs ? (we ? VALID : IDLE) : (we ? VALID_PEND : VALID);
        load = hs & we;
      end
      VALID_PEND: begin
        state_d = hs ? VALID : VALID_PEND;
        load = hs;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      reg_q <= '0;
      snap_q <= '0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q <= reg_d;
      ack_q <= we;
      ovf_q <= (we & carry) | (ovf_q & ~ovf_clr);
      if (load) snap_q <= reg_d;
    end
  end
endmodule

// File: rtl/custom_reg_ip_array.sv
// custom_reg_ip_array: NUM_CH independent register-to-hardware channels with handshaked read-back
module custom_reg_ip_array
  import custom_reg_ip_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]   reg2ip_data_i,
  input  logic [NUM_CH-1:0]                   reg2ip_we_i,
  input  logic [NUM_CH-1:0][1:0]              reg2ip_mode_i,
  output logic [NUM_CH-1:0]                   reg2ip_ack_o,
  input  logic [NUM_CH-1:0]                   ovf_clr_i,
  output logic [NUM_CH-1:0]                   ovf_o,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]   ip2reg_data_o,
  output logic [NUM_CH-1:0]                   ip2reg_valid_o,
  input  logic [NUM_CH-1:0]                   ip2reg_ready_i
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    custom_reg_ip_ch #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .wdata  (reg2ip_data_i[g]),
      .we     (reg2ip_we_i[g]),
      .mode   (reg2ip_mode_i[g]),
      .ack    (reg2ip_ack_o[g]),
      .ovf_clr(ovf_clr_i[g]),
      .ovf    (ovf_o[g]),
      .rdata  (ip2reg_data_o[g]),
      .rvalid (ip2reg_valid_o[g]),
      .rready (ip2reg_ready_i[g])
    );
  end
endmodule

// File: tb/tb_custom_reg_ip_array.sv
// tb_custom_reg_ip_array: directed plus randomized checks against a behavioural channel model
module tb_custom_reg_ip_array;
  localparam int N = 3;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic [N-1:0][31:0] data = '0, rdata;
  logic [N-1:0][1:0] mode = '0;
  logic [N-1:0] we = '0, clr = '0, ready = '0, ack, ovf, valid;
  int n_cmp = 0, n_mis = 0;
  logic [31:0] m_reg[N], m_snap[N];
  logic m_valid[N], m_pend[N], m_ack[N], m_ovf[N];

  custom_reg_ip_array #(.NUM_CH(N), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .reg2ip_data_i(data), .reg2ip_we_i(we),
    .reg2ip_mode_i(mode), .reg2ip_ack_o(ack), .ovf_clr_i(clr), .ovf_o(ovf),
    .ip2reg_data_o(rdata), .ip2reg_valid_o(valid), .ip2reg_ready_i(ready)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s ch%0d observed=%h expected=%h", tag, c, obs, exp);
    end
  endtask

  // Model: the register is an integer accumulator; read-back is "offered" / "newer value waiting"
  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      logic [32:0] s;
      logic [31:0] nv;
      logic acc, hs;
      if (rst_i) begin
        m_reg[c] = 0; m_snap[c] = 0; m_valid[c] = 0; m_pend[c] = 0; m_ack[c] = 0; m_ovf[c] = 0;
        continue;
      end
      hs = m_valid[c] && ready[c];
      acc = (mode[c] == 2'd1) || (mode[c] == 2'd2);
      s = {1'b0, m_reg[c]} + {1'b0, data[c]};
      nv = !acc ? data[c] : (mode[c] == 2'd2 && s[32]) ? 32'hFFFF_FFFF : s[31:0];
      m_ovf[c] = (we[c] && acc && s[32]) || (m_ovf[c] && !clr[c]);
      m_ack[c] = we[c];
      if (we[c]) m_reg[c] = nv;
      if (!m_valid[c]) begin
        if (we[c]) begin m_valid[c] = 1; m_snap[c] = m_reg[c]; end
      end else if (m_pend[c]) begin
        if (hs) begin m_pend[c] = 0; m_snap[c] = m_reg[c]; end
      end else if (hs) begin
        if (we[c]) m_snap[c] = m_reg[c]; else m_valid[c] = 0;
      end else if (we[c]) m_pend[c] = 1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_i);
    #1;
    for (int c = 0; c < N; c++) begin
      chk("ack", c, 32'(ack[c]), 32'(m_ack[c]));
      chk("ovf", c, 32'(ovf[c]), 32'(m_ovf[c]));
      chk("valid", c, 32'(valid[c]), 32'(m_valid[c]));
      chk("data", c, rdata[c], m_snap[c]);
    end
  endtask

  task automatic idle_in();
    rst_i = 0; we = '0; clr = '0; ready = '0; mode = '0; data = '0;
  endtask

  initial begin
    cycle();
    idle_in();
    chk("rst_valid", 0, 32'(valid), 0);
    chk("rst_ack_ovf", 0, 32'({ack, ovf}), 0);
    chk("rst_data", 1, rdata[1], 0);
    // STORE write and single handshake
    we[0] = 1; data[0] = 32'hDEAD_BEEF; cycle();
    chk("store_ack", 0, 32'(ack[0]), 1);
    chk("store_data", 0, rdata[0], 32'hDEAD_BEEF);
    idle_in(); ready[0] = 1; cycle();
    chk("store_ack_gone", 0, 32'(ack[0]), 0);
    chk("hs_valid_drop", 0, 32'(valid[0]), 0);
    // ACC_WRAP carry, clear collision, lone clear
    idle_in(); we[0] = 1; data[0] = 32'hFFFF_FFF0; cycle();
    we[0] = 1; mode[0] = 2'd1; data[0] = 32'h20; ready[0] = 1; cycle();
    chk("wrap_data", 0, rdata[0], 32'h10);
    chk("wrap_ovf", 0, 32'(ovf[0]), 1);
    chk("wrap_valid", 0, 32'(valid[0]), 1);
    we[0] = 1; mode[0] = 2'd1; data[0] = 32'hFFFF_FFFF; clr[0] = 1; ready[0] = 1; cycle();
    chk("set_beats_clr", 0, 32'(ovf[0]), 1);
    idle_in(); clr[0] = 1; ready[0] = 1; cycle();
    chk("lone_clr", 0, 32'(ovf[0]), 0);
    // ACC_SAT clamp
    idle_in(); we[0] = 1; data[0] = 32'hFFFF_FF00; cycle();
    we[0] = 1; mode[0] = 2'd2; data[0] = 32'h1000; ready[0] = 1; cycle();
    chk("sat_data", 0, rdata[0], 32'hFFFF_FFFF);
    chk("sat_ovf", 0, 32'(ovf[0]), 1);
    data[0] = 32'h1; cycle();
    chk("sat_hold", 0, rdata[0], 32'hFFFF_FFFF);
    idle_in(); clr[0] = 1; ready[0] = 1; cycle();
    // Coalescing with ready low
    idle_in(); we[0] = 1; data[0] = 5; cycle();
    data[0] = 7; cycle();
    data[0] = 9; cycle();
    chk("pend_snap", 0, rdata[0], 5);
    chk("pend_valid", 0, 32'(valid[0]), 1);
    idle_in(); ready[0] = 1; cycle();
    chk("pend_rearm", 0, rdata[0], 9);
    chk("pend_rearm_v", 0, 32'(valid[0]), 1);
    cycle();
    chk("pend_done", 0, 32'(valid[0]), 0);
    // Concurrent handshake+write on ch0 and ch2
    idle_in(); we[0] = 1; we[2] = 1; data[0] = 1; data[2] = 32'hA; cycle();
    ready[0] = 1; ready[2] = 1; data[0] = 3; data[2] = 4; cycle();
    chk("hsw_ch0", 0, rdata[0], 3);
    chk("hsw_ch2", 2, rdata[2], 4);
    chk("hsw_valid", 0, 32'(valid), 32'b101);
    idle_in(); ready = '1; cycle();
    // Reset in VALID_PEND with a same-cycle write
    idle_in(); we[0] = 1; data[0] = 5; cycle();
    data[0] = 6; cycle();
    rst_i = 1; data[0] = 7; cycle();
    chk("rstp_valid", 0, 32'(valid[0]), 0);
    chk("rstp_ack", 0, 32'(ack[0]), 0);
    idle_in(); we[0] = 1; mode[0] = 2'd1; data[0] = 32'h11; cycle();
    chk("rstp_resume", 0, rdata[0], 32'h11);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_i = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < N; c++) begin
        we[c] = 1'($urandom_range(0, 1));
        mode[c] = 2'($urandom_range(0, 3));
        data[c] = $urandom_range(0, 1) ? $urandom : {24'hFFFFFF, 8'($urandom)};
        clr[c] = ($urandom_range(0, 7) == 0);
        ready[c] = 1'($urandom_range(0, 1));
      end
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/custom_reg_ip_array.md
# custom_reg_ip_array

Parametrised register-to-hardware bridge: NUM_CH independent channels, each holding a DATA_WIDTH-bit register written from the register file side, with per-channel store/accumulate modes, a one-cycle write acknowledge and a valid/ready read-back path to the register file. It sits between the SoC peripheral register file and custom hardware, and replaces the fixed 3-channel, 1-bit-per-channel bridge with a handshaked, width- and count-generic version.

## Interface
- NUM_CH, 3, number of channels (1..32)
- DATA_WIDTH, 32, register width per channel (1..64)
- clk_i  in  1  clock; one clock domain; all ports are sampled on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- reg2ip_data_i  in  NUM_CH x DATA_WIDTH  write data per channel
- reg2ip_we_i  in  NUM_CH  write strobe per channel, one write per cycle when high
- reg2ip_mode_i  in  NUM_CH x 2  channel mode: 0 STORE, 1 ACC_WRAP, 2 ACC_SAT, 3 reserved (behaves as STORE)
- reg2ip_ack_o  out  NUM_CH  write acknowledge pulse
- ovf_clr_i  in  NUM_CH  clears the sticky overflow flag
- ovf_o  out  NUM_CH  sticky overflow flag
- ip2reg_data_o  out  NUM_CH x DATA_WIDTH  read-back snapshot
- ip2reg_valid_o  out  NUM_CH  snapshot valid
- ip2reg_ready_i  in  NUM_CH  register file accepts the snapshot

## Operation
- Channels are fully independent; nothing below couples channel i to channel j.
- Write result (next): STORE gives data; ACC_WRAP gives reg + data mod 2^DATA_WIDTH; ACC_SAT gives reg + data, clamped to all-ones on carry-out.
- Carry-out in ACC_WRAP or ACC_SAT sets ovf. ovf stays set until ovf_clr_i. If set and clear occur in the same cycle, set wins.
- Every write is acknowledged and produces an update, even when the value does not change.
- Read-back FSM per channel. Handshake means valid & ready at a rising edge.
  - IDLE: a write moves to VALID, with snapshot = next.
  - VALID, handshake and no write: moves to IDLE.
  - VALID, handshake and write: stays in VALID, with snapshot = next.
  - VALID, write and no handshake: moves to VALID_PEND; the snapshot is unchanged.
  - VALID_PEND, handshake: moves to VALID, with snapshot = the register value after this edge, including any same-cycle write.
  - VALID_PEND, no handshake: stays; further writes coalesce.
- ip2reg_valid_o is high in VALID and VALID_PEND.
- ip2reg_data_o is stable while valid is high and no handshake occurs.
- ready while valid is low is ignored.
- reg2ip_mode_i is sampled per write; changing it between writes is legal.

## Timing
- Write at cycle t (we high at edge t):
  - reg holds next from t+1.
  - reg2ip_ack_o is high for cycle t+1 only.
  - From IDLE, ip2reg_valid_o rises in t+1 with data = next.
  - ovf is updated in t+1.
- Back-to-back writes give back-to-back ack pulses, one per write.
- Handshake at edge t: valid drops in t+1, unless the FSM re-arms as above.
- Reset (rst_i high at an edge) applies in all states, including mid-handshake or VALID_PEND. After reset:
  - all registers and snapshots are 0;
  - ack, ovf and valid are 0;
  - the FSM is IDLE;
  - a write in the same cycle as reset is discarded and not acknowledged.

## Structure
- Package custom_reg_ip_pkg holds:
  - the mode_e enum (STORE, ACC_WRAP, ACC_SAT, RSVD);
  - the rd_state_e enum (IDLE, VALID, VALID_PEND);
  - a function computing next and carry from mode, reg and data.
- Sub-module custom_reg_ip_ch implements one channel (register, ack, ovf, FSM). The top is a generate loop of NUM_CH instances with no logic of its own.

## Test plan
- Reset and STORE (DATA_WIDTH=32):
  - After reset, all outputs are 0.
  - Write 0xDEADBEEF on ch0 at t: ack pulses in t+1 only, valid rises in t+1 with data 0xDEADBEEF.
  - ready at t+1 gives valid 0 at t+2.
- ACC_WRAP:
  - Starting from 0xFFFFFFF0, write 0x20: data becomes 0x00000010 and ovf=1.
  - ovf_clr_i plus a carrying write in the same cycle leaves ovf=1.
  - A lone clear gives ovf=0.
- ACC_SAT:
  - Starting from 0xFFFFFF00, write 0x1000: data becomes 0xFFFFFFFF and ovf=1.
  - A further write of 1 keeps data at 0xFFFFFFFF.
- Coalescing with ready held low:
  - Write 5, then 7, then 9 (STORE): snapshot stays 5 in VALID_PEND.
  - Raise ready: data 5 is accepted, then valid re-asserts next cycle with data 9.
  - A second handshake returns the FSM to IDLE.
- Handshake and write in the same cycle, in VALID with ready=1:
  - A write of 0x3 moves snapshot to 0x3 and valid stays 1.
  - Channels 0 and 2 are exercised concurrently with no cross-talk (NUM_CH=3).
- Reset in VALID_PEND with a write in the same cycle:
  - Next cycle, valid=0, reg=0 and ack=0.
  - Normal operation resumes on the next write.
